// File: rtl/even_pipe_issue_ctrl.sv
// Issue controller for the even pipe: a shifting scoreboard of in-flight results
// gates acceptance of dependent instructions until their operand can be forwarded.
module even_pipe_issue_ctrl #(
  parameter int NUM_STAGES = 7
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_ra_addr,
  input  logic [6:0]  in_rb_addr,
  input  logic [6:0]  in_rc_addr,
  input  logic [2:0]  in_src_used,
  input  logic [6:0]  in_rt_addr,
  input  logic [1:0]  in_lat_class,
  input  logic        flush,
  output logic        issue_valid,
  output logic [6:0]  issue_rt_addr,
  output logic [15:0] stall_count
);

  // Handshake: an instruction is taken in any cycle where in_valid and in_ready
  // are both high; in_ready never looks at in_valid, and decode holds its
  // instruction unchanged until it is taken.

  logic [NUM_STAGES:1] sb_valid;
  logic [6:0]          sb_rt  [1:NUM_STAGES];
  logic [2:0]          sb_lat [1:NUM_STAGES];
  logic                hazard;
  logic                handshake;
  logic [2:0]          new_lat;

  always_comb begin
    case (in_lat_class)
      2'b00:   new_lat = 3'd2;
      2'b01:   new_lat = 3'd4;
      2'b10:   new_lat = 3'd6;
      default: new_lat = 3'd7;
    endcase
  end

  // An entry at stage s can forward to a consumer only once s+1 reaches its latency.
  always_comb begin
    hazard = 1'b0;
    for (int s = 1; s <= NUM_STAGES; s++) begin
      if (sb_valid[s] && (s + 1 < int'(sb_lat[s])) &&
          ((in_src_used[0] && (in_ra_addr == sb_rt[s])) ||
           (in_src_used[1] && (in_rb_addr == sb_rt[s])) ||
           (in_src_used[2] && (in_rc_addr == sb_rt[s]))))
        hazard = 1'b1;
    end
  end

  assign in_ready  = !hazard && !flush;
  assign handshake = in_valid && in_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sb_valid      <= '0;
      issue_valid   <= 1'b0;
      issue_rt_addr <= 7'd0;
      for (int k = 1; k <= NUM_STAGES; k++) begin
        sb_rt[k]  <= 7'd0;
        sb_lat[k] <= 3'd0;
      end
    end else begin
      if (flush)
        sb_valid <= '0;
      else
        sb_valid <= {sb_valid[NUM_STAGES-1:1], handshake};
      sb_rt[1]  <= in_rt_addr;
      sb_lat[1] <= new_lat;
      for (int k = 2; k <= NUM_STAGES; k++) begin
        sb_rt[k]  <= sb_rt[k-1];
        sb_lat[k] <= sb_lat[k-1];
      end
      issue_valid <= handshake;
      if (handshake)
        issue_rt_addr <= in_rt_addr;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      stall_count <= 16'd0;
    else if (in_valid && hazard && !flush && (stall_count != 16'hFFFF))
      stall_count <= stall_count + 16'd1;
  end

endmodule
